// File: rtl/polygon_loader_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | polygon_loader_pkg                                                      |
// | Shared types and constants for the polygon loader.                      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package polygon_loader_pkg;

  localparam int C_WORLD_BITS = 32;
  localparam int MIN_VERTICES = 3;

  typedef logic signed [C_WORLD_BITS-1:0] world_t;

  typedef struct packed {
    world_t x;
    world_t y;
  } vertex_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/polygon_loader_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | polygon_loader_if                                                       |
// | Load request, BRAM read bus and status signals of the polygon loader.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface polygon_loader_if #(
  parameter int ADDR_BITS        = 10,
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32
);
  logic                                  load_start_in;
  logic [ADDR_BITS-1:0]                  base_addr_in;
  logic [$clog2(MAX_NUM_VERTICES+1)-1:0] count_in;
  logic                                  swap_in;
  logic [ADDR_BITS-1:0]                  bram_addr_out;
  logic [2*WORLD_BITS-1:0]               bram_data_in;
  logic                                  busy_out;
  logic                                  done_out;
  logic                                  error_out;

  modport master (
    output load_start_in, base_addr_in, count_in, swap_in, bram_data_in,
    input  bram_addr_out, busy_out, done_out, error_out
  );

  modport slave (
    input  load_start_in, base_addr_in, count_in, swap_in, bram_data_in,
    output bram_addr_out, busy_out, done_out, error_out
  );
endinterface
`default_nettype wire

// File: rtl/polygon_loader_poly_bank.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | poly_bank                                                               |
// | Vertex register bank: indexed write, bulk copy-in, parallel read-out.   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module poly_bank #(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32,
  parameter int IDX_BITS         = 5
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_wr_en,
  input  wire logic [IDX_BITS-1:0]          i_wr_idx,
  input  wire logic signed [WORLD_BITS-1:0] i_wr_x,
  input  wire logic signed [WORLD_BITS-1:0] i_wr_y,
  input  wire logic                         i_copy_en,
  input  wire logic signed [WORLD_BITS-1:0] i_copy_xs [MAX_NUM_VERTICES],
  input  wire logic signed [WORLD_BITS-1:0] i_copy_ys [MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0]      o_xs [MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0]      o_ys [MAX_NUM_VERTICES]
);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        o_xs[i] <= '0;
        o_ys[i] <= '0;
      end
    end else if (i_copy_en) begin
      o_xs <= i_copy_xs;
      o_ys <= i_copy_ys;
    end else if (i_wr_en) begin
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        if (i_wr_idx == IDX_BITS'(i)) begin
          o_xs[i] <= i_wr_x;
          o_ys[i] <= i_wr_y;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/polygon_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | polygon_loader                                                          |
// | Fetches a vertex list from BRAM into a shadow bank; swaps to active on  |
// | frame boundary. Optional bounding box: define POLY_LOADER_BBOX_EN.      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module polygon_loader
  import polygon_loader_pkg::*;
#(
  parameter int WORLD_BITS       = 32,
  parameter int MAX_NUM_VERTICES = 32,
  parameter int ADDR_BITS        = 10,
  parameter int BRAM_LATENCY     = 2
) (
  input  wire logic                            clk_in,
  input  wire logic                            rst_in,
  polygon_loader_if.slave                      bus,
  output logic signed [WORLD_BITS-1:0]         poly_xs_out [MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0]         poly_ys_out [MAX_NUM_VERTICES],
  output logic [$clog2(MAX_NUM_VERTICES+1)-1:0] num_points_out
`ifdef POLY_LOADER_BBOX_EN
  ,
  output logic signed [WORLD_BITS-1:0]         bbox_min_x_out,
  output logic signed [WORLD_BITS-1:0]         bbox_max_x_out,
  output logic signed [WORLD_BITS-1:0]         bbox_min_y_out,
  output logic signed [WORLD_BITS-1:0]         bbox_max_y_out
`endif
);

  localparam int CNT_BITS = $clog2(MAX_NUM_VERTICES + 1);
  localparam int IDX_BITS = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;

  state_t                          r_state, w_next;
  logic [ADDR_BITS-1:0]            r_addr;
  logic [CNT_BITS-1:0]             r_count, r_idx, r_shadow_count;
  logic                            r_shadow_valid, r_error;
  logic [BRAM_LATENCY-1:0]         r_pipe_vld;
  logic [IDX_BITS-1:0]             r_pipe_idx [BRAM_LATENCY];
  logic signed [WORLD_BITS-1:0]    w_sh_xs [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0]    w_sh_ys [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0]    w_wr_x, w_wr_y;
  logic [IDX_BITS-1:0]             w_wr_idx;
  logic [CNT_BITS-1:0]             w_last_idx;
  logic w_count_ok, w_idle, w_accept, w_reject, w_swap, w_issue, w_last_issue;
  logic w_wr_en, w_last_write;

  assign w_count_ok   = (bus.count_in >= CNT_BITS'(MIN_VERTICES)) &&
                        (bus.count_in <= CNT_BITS'(MAX_NUM_VERTICES));
  assign w_idle       = (r_state == IDLE);
  assign w_accept     = w_idle && bus.load_start_in && w_count_ok;
  assign w_reject     = w_idle && bus.load_start_in && !w_count_ok;
  assign w_swap       = w_idle && bus.swap_in && r_shadow_valid;
  assign w_last_idx   = r_count - CNT_BITS'(1);
  assign w_issue      = (r_state == FETCH);
  assign w_last_issue = w_issue && (r_idx == w_last_idx);
  // The oldest pipeline stage lines up with the word now on bram_data_in.
  assign w_wr_en      = r_pipe_vld[BRAM_LATENCY-1];
  assign w_wr_idx     = r_pipe_idx[BRAM_LATENCY-1];
  assign w_last_write = w_wr_en && (CNT_BITS'(w_wr_idx) == w_last_idx);
  assign w_wr_x       = bus.bram_data_in[2*WORLD_BITS-1:WORLD_BITS];
  assign w_wr_y       = bus.bram_data_in[WORLD_BITS-1:0];

  assign bus.bram_addr_out = r_addr;
  assign bus.error_out     = r_error;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.busy_out = 1'b1;
    bus.done_out = 1'b0;
    case (r_state)
      IDLE: begin
        bus.busy_out = 1'b0;
        if (w_accept) w_next = FETCH;
      end
      FETCH: if (w_last_issue) w_next = DRAIN;
      DRAIN: if (w_last_write) w_next = DONE;
      DONE: begin
        bus.done_out = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_addr         <= '0;
      r_count        <= '0;
      r_idx          <= '0;
      r_shadow_count <= '0;
      r_shadow_valid <= 1'b0;
      r_error        <= 1'b0;
      num_points_out <= '0;
      r_pipe_vld     <= '0;
    end else begin
      r_error <= w_reject;
      if (w_accept) begin
        r_addr         <= bus.base_addr_in;
        r_count        <= bus.count_in;
        r_shadow_count <= bus.count_in;
        r_idx          <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + ADDR_BITS'(1);
        r_idx  <= r_idx + CNT_BITS'(1);
      end
      if (w_swap) num_points_out <= r_shadow_count;
      if (w_accept || w_swap)    r_shadow_valid <= 1'b0;
      else if (r_state == DONE)  r_shadow_valid <= 1'b1;
      r_pipe_vld[0] <= w_issue;
      for (int i = 1; i < BRAM_LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    r_pipe_idx[0] <= r_idx[IDX_BITS-1:0];
    for (int i = 1; i < BRAM_LATENCY; i++) r_pipe_idx[i] <= r_pipe_idx[i-1];
  end

  poly_bank #(
    .WORLD_BITS(WORLD_BITS), .MAX_NUM_VERTICES(MAX_NUM_VERTICES), .IDX_BITS(IDX_BITS)
  ) u_shadow (
    .clk(clk_in), .rst(rst_in),
    .i_wr_en(w_wr_en), .i_wr_idx(w_wr_idx), .i_wr_x(w_wr_x), .i_wr_y(w_wr_y),
    .i_copy_en(1'b0), .i_copy_xs(poly_xs_out), .i_copy_ys(poly_ys_out),
    .o_xs(w_sh_xs), .o_ys(w_sh_ys)
  );

  poly_bank #(
    .WORLD_BITS(WORLD_BITS), .MAX_NUM_VERTICES(MAX_NUM_VERTICES), .IDX_BITS(IDX_BITS)
  ) u_active (
    .clk(clk_in), .rst(rst_in),
    .i_wr_en(1'b0), .i_wr_idx('0), .i_wr_x('0), .i_wr_y('0),
    .i_copy_en(w_swap), .i_copy_xs(w_sh_xs), .i_copy_ys(w_sh_ys),
    .o_xs(poly_xs_out), .o_ys(poly_ys_out)
  );

`ifdef POLY_LOADER_BBOX_EN
  logic signed [WORLD_BITS-1:0] r_sh_min_x, r_sh_max_x, r_sh_min_y, r_sh_max_y;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sh_min_x <= '0; r_sh_max_x <= '0; r_sh_min_y <= '0; r_sh_max_y <= '0;
      bbox_min_x_out <= '0; bbox_max_x_out <= '0;
      bbox_min_y_out <= '0; bbox_max_y_out <= '0;
    end else begin
      // Vertex 0 seeds the box so stale bounds from an older polygon never leak in.
      if (w_wr_en && (w_wr_idx == '0)) begin
        r_sh_min_x <= w_wr_x; r_sh_max_x <= w_wr_x;
        r_sh_min_y <= w_wr_y; r_sh_max_y <= w_wr_y;
      end else if (w_wr_en) begin
        if (w_wr_x < r_sh_min_x) r_sh_min_x <= w_wr_x;
        if (w_wr_x > r_sh_max_x) r_sh_max_x <= w_wr_x;
        if (w_wr_y < r_sh_min_y) r_sh_min_y <= w_wr_y;
        if (w_wr_y > r_sh_max_y) r_sh_max_y <= w_wr_y;
      end
      if (w_swap) begin
        bbox_min_x_out <= r_sh_min_x; bbox_max_x_out <= r_sh_max_x;
        bbox_min_y_out <= r_sh_min_y; bbox_max_y_out <= r_sh_max_y;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_polygon_loader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_polygon_loader                                                       |
// | Directed self-checking bench for polygon_loader with a 2-cycle BRAM.    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_polygon_loader;

  localparam int W = 32;
  localparam int MAXV = 32;
  localparam int AB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W-1:0] xs [MAXV];
  logic signed [W-1:0] ys [MAXV];
  logic [5:0] np;
  logic [2*W-1:0] mem [1024];
  logic [2*W-1:0] r_d1;
  int checks = 0;
  int errors = 0;
`ifdef POLY_LOADER_BBOX_EN
  logic signed [W-1:0] bminx, bmaxx, bminy, bmaxy;
`endif

  polygon_loader_if #(.ADDR_BITS(AB), .WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV)) bus ();

  polygon_loader #(
    .WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV), .ADDR_BITS(AB), .BRAM_LATENCY(2)
  ) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus),
    .poly_xs_out(xs), .poly_ys_out(ys), .num_points_out(np)
`ifdef POLY_LOADER_BBOX_EN
    , .bbox_min_x_out(bminx), .bbox_max_x_out(bmaxx)
    , .bbox_min_y_out(bminy), .bbox_max_y_out(bmaxy)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model: address seen in cycle k returns data in cycle k+2.
  always @(posedge clk) begin
    r_d1 <= mem[bus.bram_addr_out];
    bus.bram_data_in <= r_d1;
  end

  function automatic logic [2*W-1:0] pack(input int x, input int y);
    return {x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AB-1:0] base, input logic [5:0] cnt);
    bus.base_addr_in  = base;
    bus.count_in      = cnt;
    bus.load_start_in = 1'b1;
    tick();
    bus.load_start_in = 1'b0;
  endtask

  // Returns the cycle index (relative to the load_start cycle) of done_out, -1 on timeout.
  task automatic wait_done(input int start, output int n);
    n = start;
    while (bus.done_out !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (bus.done_out !== 1'b1) n = -1;
  endtask

  task automatic do_swap();
    bus.swap_in = 1'b1;
    tick();
    bus.swap_in = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy_out); end
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done_out); end
    checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL reset_error got %0b want 0", bus.error_out); end
    checks++; if (np !== 6'd0) begin errors++; $display("FAIL reset_np got %0d want 0", np); end
    checks++; if (xs[1] !== 32'sd0) begin errors++; $display("FAIL reset_xs1 got %0d want 0", xs[1]); end
  endtask

  task automatic test_square();
    int n;
    mem[16] = pack(0, 0);   mem[17] = pack(100, 0);
    mem[18] = pack(100, 100); mem[19] = pack(0, 100);
    start_load(10'h010, 6'd4);
    checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL sq_busy got %0b want 1", bus.busy_out); end
    checks++; if (bus.bram_addr_out !== 10'h010) begin errors++; $display("FAIL sq_addr0 got %h want 010", bus.bram_addr_out); end
    wait_done(1, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL sq_latency got %0d want 7", n); end
    checks++; if (np !== 6'd0) begin errors++; $display("FAIL sq_np_preswap got %0d want 0", np); end
    tick(); tick();
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL sq_idle_busy got %0b want 0", bus.busy_out); end
    do_swap();
    checks++; if (np !== 6'd4) begin errors++; $display("FAIL sq_np got %0d want 4", np); end
    checks++; if (xs[1] !== 32'sd100) begin errors++; $display("FAIL sq_xs1 got %0d want 100", xs[1]); end
    checks++; if (ys[2] !== 32'sd100) begin errors++; $display("FAIL sq_ys2 got %0d want 100", ys[2]); end
    checks++; if (ys[1] !== 32'sd0) begin errors++; $display("FAIL sq_ys1 got %0d want 0", ys[1]); end
  endtask

  task automatic test_wrap();
    int n;
    logic [AB-1:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    mem[10'h3FE] = pack(1, 2); mem[10'h3FF] = pack(3, 4);
    mem[10'h000] = pack(5, 6); mem[10'h001] = pack(7, 8);
    start_load(10'h3FE, 6'd4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.bram_addr_out !== exp_a[k]) begin
        errors++; $display("FAIL wrap_addr%0d got %h want %h", k, bus.bram_addr_out, exp_a[k]);
      end
      tick();
    end
    wait_done(5, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL wrap_latency got %0d want 7", n); end
    tick();
    do_swap();
    checks++; if (xs[0] !== 32'sd1) begin errors++; $display("FAIL wrap_xs0 got %0d want 1", xs[0]); end
    checks++; if (xs[2] !== 32'sd5) begin errors++; $display("FAIL wrap_xs2 got %0d want 5", xs[2]); end
    checks++; if (ys[3] !== 32'sd8) begin errors++; $display("FAIL wrap_ys3 got %0d want 8", ys[3]); end
  endtask

  task automatic test_invalid();
    logic [5:0] bad [2];
    bad[0] = 6'd2; bad[1] = 6'd33;
    for (int k = 0; k < 2; k++) begin
      start_load(10'h010, bad[k]);
      checks++; if (bus.error_out !== 1'b1) begin errors++; $display("FAIL inv%0d_error got %0b want 1", k, bus.error_out); end
      checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL inv%0d_busy got %0b want 0", k, bus.busy_out); end
      tick();
      checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL inv%0d_error_pulse got %0b want 0", k, bus.error_out); end
    end
    checks++; if (np !== 6'd4 || xs[0] !== 32'sd1) begin errors++; $display("FAIL inv_active got np=%0d xs0=%0d want 4,1", np, xs[0]); end
  endtask

  task automatic test_ignored();
    int n;
    for (int k = 0; k < 5; k++) mem[10'h100 + k] = pack(10 * (k + 1), 10 * (k + 1) + 1);
    start_load(10'h100, 6'd5);
    tick();
    bus.swap_in = 1'b1; bus.load_start_in = 1'b1;
    bus.base_addr_in = 10'h200; bus.count_in = 6'd3;
    tick();
    bus.swap_in = 1'b0; bus.load_start_in = 1'b0;
    checks++; if (bus.error_out !== 1'b0) begin errors++; $display("FAIL ign_error got %0b want 0", bus.error_out); end
    checks++; if (np !== 6'd4) begin errors++; $display("FAIL ign_swap_fetch got np=%0d want 4", np); end
    wait_done(3, n);
    checks++; if (n !== 8) begin errors++; $display("FAIL ign_latency got %0d want 8", n); end
    bus.swap_in = 1'b1;
    tick();
    bus.swap_in = 1'b0;
    checks++; if (np !== 6'd4) begin errors++; $display("FAIL ign_swap_done got np=%0d want 4", np); end
    do_swap();
    checks++; if (np !== 6'd5) begin errors++; $display("FAIL ign_np got %0d want 5", np); end
    checks++; if (xs[4] !== 32'sd50) begin errors++; $display("FAIL ign_xs4 got %0d want 50", xs[4]); end
    checks++; if (ys[0] !== 32'sd11) begin errors++; $display("FAIL ign_ys0 got %0d want 11", ys[0]); end
  endtask

  task automatic test_reset_mid();
    start_load(10'h100, 6'd5);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", bus.busy_out); end
    checks++; if (np !== 6'd0) begin errors++; $display("FAIL rmid_np got %0d want 0", np); end
    checks++; if (xs[4] !== 32'sd0) begin errors++; $display("FAIL rmid_xs4 got %0d want 0", xs[4]); end
    tick(); tick();
    checks++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL rmid_done got %0b want 0", bus.done_out); end
  endtask

  task automatic test_swap_with_load();
    int n;
    mem[10'h020] = pack(-5, 3); mem[10'h021] = pack(7, -2); mem[10'h022] = pack(1, 9);
    start_load(10'h010, 6'd4);
    wait_done(1, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL swl_sq_latency got %0d want 7", n); end
    tick();
    bus.swap_in = 1'b1; bus.load_start_in = 1'b1;
    bus.base_addr_in = 10'h020; bus.count_in = 6'd3;
    tick();
    bus.swap_in = 1'b0; bus.load_start_in = 1'b0;
    checks++; if (np !== 6'd4 || xs[1] !== 32'sd100) begin errors++; $display("FAIL swl_old got np=%0d xs1=%0d want 4,100", np, xs[1]); end
    checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL swl_busy got %0b want 1", bus.busy_out); end
    wait_done(1, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL swl_tri_latency got %0d want 6", n); end
    tick();
    do_swap();
    checks++; if (np !== 6'd3) begin errors++; $display("FAIL swl_np got %0d want 3", np); end
    checks++; if (xs[0] !== -32'sd5) begin errors++; $display("FAIL swl_xs0 got %0d want -5", xs[0]); end
    checks++; if (ys[1] !== -32'sd2) begin errors++; $display("FAIL swl_ys1 got %0d want -2", ys[1]); end
    checks++; if (ys[2] !== 32'sd9) begin errors++; $display("FAIL swl_ys2 got %0d want 9", ys[2]); end
`ifdef POLY_LOADER_BBOX_EN
    checks++; if (bminx !== -32'sd5) begin errors++; $display("FAIL bbox_minx got %0d want -5", bminx); end
    checks++; if (bmaxx !== 32'sd7) begin errors++; $display("FAIL bbox_maxx got %0d want 7", bmaxx); end
    checks++; if (bminy !== -32'sd2) begin errors++; $display("FAIL bbox_miny got %0d want -2", bminy); end
    checks++; if (bmaxy !== 32'sd9) begin errors++; $display("FAIL bbox_maxy got %0d want 9", bmaxy); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    bus.load_start_in = 1'b0;
    bus.swap_in       = 1'b0;
    bus.base_addr_in  = '0;
    bus.count_in      = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_square();
    test_wrap();
    test_invalid();
    test_ignored();
    test_reset_mid();
    test_swap_with_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
